// File: rtl/unique_sel_checker.sv
// rtl/unique_sel_checker.sv - N-way priority selector with unique/unique0/priority violation checking (optional UNIQUE_CHK_DISPLAY_EN)
module unique_sel_checker #(
    parameter int N        = 4,
    parameter int MODE     = 0,
    parameter int HAS_ELSE = 0,
    parameter int CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [N-1:0]         cond,
    input  logic                 clr,
    output logic                 out_valid,
    output logic [$clog2(N)-1:0] sel_idx,
    output logic                 sel_hit,
    output logic                 sel_else,
    output logic                 no_match_err,
    output logic                 multi_match_err,
    output logic [CNT_W-1:0]     no_cnt,
    output logic [CNT_W-1:0]     multi_cnt,
    output logic                 fault
);

    localparam int              IW       = $clog2(N);
    localparam logic [N-1:0]    COND_ONE = {{(N-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    generate
        if (MODE < 0 || MODE > 2) begin : g_bad_mode
            $error("unique_sel_checker: illegal MODE %0d (0=unique0, 1=unique, 2=priority)", MODE);
        end
        if (N < 2 || N > 32) begin : g_bad_n
            $error("unique_sel_checker: N=%0d outside 2..32", N);
        end
    endgenerate

    typedef enum logic {ST_OK, ST_FAULT} state_t;

    state_t         state;
    state_t         state_next;
    logic [IW-1:0]  enc_idx;
    logic           any_hit;
    logic           many_hit;
    logic           no_viol;
    logic           multi_viol;

    // Lowest set condition bit wins, mirroring the first true branch of an if chain
    always_comb begin
        enc_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (cond[i]) enc_idx = IW'(i);
        end
    end

    // Classify the current sample; clearing the lowest set bit leaves nonzero only when several are set
    always_comb begin
        any_hit    = |cond;
        many_hit   = |(cond & (cond - COND_ONE));
        no_viol    = in_valid && !any_hit && (HAS_ELSE == 0) && (MODE != 0);
        multi_viol = in_valid && many_hit && (MODE != 2);
    end

    // Register the per-sample result; idle cycles drive every result field to zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid       <= 1'b0;
            sel_idx         <= '0;
            sel_hit         <= 1'b0;
            sel_else        <= 1'b0;
            no_match_err    <= 1'b0;
            multi_match_err <= 1'b0;
        end else begin
            out_valid       <= in_valid;
            sel_idx         <= in_valid ? enc_idx : '0;
            sel_hit         <= in_valid && any_hit;
            sel_else        <= in_valid && !any_hit && (HAS_ELSE != 0);
            no_match_err    <= no_viol;
            multi_match_err <= multi_viol;
        end
    end

    // Saturating violation counters; clr wipes them first, then the current violation counts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            no_cnt    <= '0;
            multi_cnt <= '0;
        end else if (clr) begin
            no_cnt    <= no_viol ? CNT_ONE : '0;
            multi_cnt <= multi_viol ? CNT_ONE : '0;
        end else begin
            if (no_viol && no_cnt != CNT_MAX) no_cnt <= no_cnt + CNT_ONE;
            if (multi_viol && multi_cnt != CNT_MAX) multi_cnt <= multi_cnt + CNT_ONE;
        end
    end

    // Fault state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_OK;
        else     state <= state_next;
    end

    // A violation always forces FAULT; clr only returns to OK on a clean cycle
    always_comb begin
        state_next = state;
        if (no_viol || multi_viol) state_next = ST_FAULT;
        else if (clr)              state_next = ST_OK;
    end

    // Sticky fault flag decoded from the state
    always_comb begin
        fault = (state == ST_FAULT);
    end

`ifdef UNIQUE_CHK_DISPLAY_EN
    function automatic string mode_name();
        case (MODE)
            0:       return "unique0";
            1:       return "unique";
            default: return "priority";
        endcase
    endfunction

    // Simulation-only echo of violations, in the spirit of simulator run-time warnings
    always @(posedge clk) begin
        if (!rst && no_viol)
            $display("%0t unique_sel_checker: no match (%s) cond=%b", $time, mode_name(), cond);
        if (!rst && multi_viol)
            $display("%0t unique_sel_checker: multiple match (%s) cond=%b", $time, mode_name(), cond);
    end
`endif

endmodule

// File: tb/tb_unique_sel_checker.sv
// tb/tb_unique_sel_checker.sv - randomized and directed bench for unique_sel_checker across four configurations
module tb_unique_sel_checker;

    localparam int ND = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] cond;
    logic       clr;

    logic       o_valid [ND];
    logic [1:0] o_idx   [ND];
    logic       o_hit   [ND];
    logic       o_else  [ND];
    logic       o_no    [ND];
    logic       o_multi [ND];
    logic [7:0] o_nc    [ND];
    logic [7:0] o_mc    [ND];
    logic       o_fault [ND];

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state and expectations
    int e_valid [ND];
    int e_idx   [ND];
    int e_hit   [ND];
    int e_else  [ND];
    int e_no    [ND];
    int e_multi [ND];
    int e_nc    [ND];
    int e_mc    [ND];
    int e_fault [ND];

    always #5 clk = ~clk;

    // instance 0: unique0, 1: unique with 2-bit counters, 2: priority, 3: priority with else
    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int MD = (g == 0) ? 0 : (g == 1) ? 1 : 2;
        localparam int HE = (g == 3) ? 1 : 0;
        localparam int CW = (g == 1) ? 2 : 8;
        logic [CW-1:0] nc;
        logic [CW-1:0] mc;
        unique_sel_checker #(.N(4), .MODE(MD), .HAS_ELSE(HE), .CNT_W(CW)) dut (
            .clk            (clk),
            .rst            (rst),
            .in_valid       (in_valid),
            .cond           (cond),
            .clr            (clr),
            .out_valid      (o_valid[g]),
            .sel_idx        (o_idx[g]),
            .sel_hit        (o_hit[g]),
            .sel_else       (o_else[g]),
            .no_match_err   (o_no[g]),
            .multi_match_err(o_multi[g]),
            .no_cnt         (nc),
            .multi_cnt      (mc),
            .fault          (o_fault[g])
        );
        assign o_nc[g] = 8'(nc);
        assign o_mc[g] = 8'(mc);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int cfg_mode(int g);
        return (g == 0) ? 0 : (g == 1) ? 1 : 2;
    endfunction

    function automatic int cfg_max(int g);
        return (g == 1) ? 3 : 255;
    endfunction

    task automatic model_reset();
        for (int g = 0; g < ND; g++) begin
            e_valid[g] = 0; e_idx[g] = 0; e_hit[g] = 0; e_else[g] = 0;
            e_no[g] = 0; e_multi[g] = 0; e_nc[g] = 0; e_mc[g] = 0; e_fault[g] = 0;
        end
    endtask

    // behavioural rules: count set bits, first set bit from the bottom, clear-then-count
    task automatic model_step(input int v, input logic [3:0] c, input int cl);
        int ones;
        int low;
        int vno;
        int vm;
        ones = $countones(c);
        low  = 0;
        while (low < 4 && !c[low]) low++;
        if (low == 4) low = 0;
        for (int g = 0; g < ND; g++) begin
            vno = (v != 0 && ones == 0 && g != 3 && cfg_mode(g) != 0) ? 1 : 0;
            vm  = (v != 0 && ones > 1 && cfg_mode(g) != 2) ? 1 : 0;
            e_valid[g] = v;
            e_idx[g]   = v ? low : 0;
            e_hit[g]   = (v != 0 && ones > 0) ? 1 : 0;
            e_else[g]  = (v != 0 && ones == 0 && g == 3) ? 1 : 0;
            e_no[g]    = vno;
            e_multi[g] = vm;
            if (cl != 0) begin
                e_nc[g] = vno;
                e_mc[g] = vm;
            end else begin
                e_nc[g] = (e_nc[g] + vno > cfg_max(g)) ? cfg_max(g) : e_nc[g] + vno;
                e_mc[g] = (e_mc[g] + vm > cfg_max(g)) ? cfg_max(g) : e_mc[g] + vm;
            end
            if (vno != 0 || vm != 0) e_fault[g] = 1;
            else if (cl != 0)        e_fault[g] = 0;
        end
    endtask

    task automatic check_all(input string tag);
        for (int g = 0; g < ND; g++) begin
            check($sformatf("%s.d%0d.out_valid", tag, g), o_valid[g], e_valid[g]);
            check($sformatf("%s.d%0d.sel_idx", tag, g), o_idx[g], e_idx[g]);
            check($sformatf("%s.d%0d.sel_hit", tag, g), o_hit[g], e_hit[g]);
            check($sformatf("%s.d%0d.sel_else", tag, g), o_else[g], e_else[g]);
            check($sformatf("%s.d%0d.no_match_err", tag, g), o_no[g], e_no[g]);
            check($sformatf("%s.d%0d.multi_match_err", tag, g), o_multi[g], e_multi[g]);
            check($sformatf("%s.d%0d.no_cnt", tag, g), o_nc[g], e_nc[g]);
            check($sformatf("%s.d%0d.multi_cnt", tag, g), o_mc[g], e_mc[g]);
            check($sformatf("%s.d%0d.fault", tag, g), o_fault[g], e_fault[g]);
        end
    endtask

    // drive one sample, clock it, then compare every instance against the model
    task automatic cycle(input string tag, input int v, input logic [3:0] c, input int cl);
        in_valid = (v != 0);
        cond     = c;
        clr      = (cl != 0);
        @(posedge clk);
        model_step(v, c, cl);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; cond = '0; clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // zero-match then multi-match
        cycle("zero", 1, 4'b0000, 0);
        check("zero.d0.fault_const", o_fault[0], 0);
        check("zero.d1.no_cnt_const", o_nc[1], 1);
        check("zero.d3.sel_else_const", o_else[3], 1);
        cycle("multi", 1, 4'b0110, 0);
        check("multi.d0.sel_idx_const", o_idx[0], 1);
        check("multi.d0.multi_cnt_const", o_mc[0], 1);
        check("multi.d2.multi_err_const", o_multi[2], 0);
        cycle("top", 1, 4'b1000, 0);
        check("top.d1.sel_idx_const", o_idx[1], 3);
        check("top.d1.fault_const", o_fault[1], 1);
        cycle("all", 1, 4'b1111, 0);
        check("all.d2.sel_idx_const", o_idx[2], 0);
        cycle("idle", 0, 4'b0101, 0);

        // saturation of the 2-bit counter
        cycle("clr0", 0, 4'b0000, 1);
        for (int k = 0; k < 5; k++) begin
            cycle($sformatf("sat%0d", k), 1, 4'b0011, 0);
            check($sformatf("sat%0d.d1.multi_cnt_const", k), o_mc[1], (k < 3) ? k + 1 : 3);
        end

        // clr together with a violation
        cycle("clr1", 0, 4'b0000, 1);
        cycle("pre_m0", 1, 4'b1100, 0);
        cycle("pre_m1", 1, 4'b1010, 0);
        for (int k = 0; k < 3; k++) cycle($sformatf("pre_z%0d", k), 1, 4'b0000, 0);
        check("pre.d1.no_cnt_const", o_nc[1], 3);
        check("pre.d1.multi_cnt_const", o_mc[1], 2);
        cycle("clr_viol", 1, 4'b0000, 1);
        check("clr_viol.d1.no_cnt_const", o_nc[1], 1);
        check("clr_viol.d1.multi_cnt_const", o_mc[1], 0);
        check("clr_viol.d1.fault_const", o_fault[1], 1);
        cycle("clr_alone", 0, 4'b0000, 1);
        check("clr_alone.d1.fault_const", o_fault[1], 0);

        // randomized traffic
        for (int k = 0; k < 300; k++) begin
            cycle($sformatf("rnd%0d", k), ($urandom_range(0, 3) != 0) ? 1 : 0,
                  4'($urandom), ($urandom_range(0, 7) == 0) ? 1 : 0);
        end

        // asynchronous reset mid-cycle with state present
        cycle("arm0", 1, 4'b0110, 0);
        cycle("arm1", 1, 4'b0000, 0);
        check("arm.d1.fault_const", o_fault[1], 1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        in_valid = 1'b1;
        cond     = 4'b0110;
        @(posedge clk);
        #1;
        check_all("rst_hold");
        rst = 1'b0;
        cycle("post_rst", 0, 4'b0000, 0);
        cycle("post_rst1", 1, 4'b0100, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
